// File: rtl/conv_enc_pkg.sv
// Shared definitions for the convolutional-encoder block scheduler:
// FSM state encoding, default subblock lengths and counter width.
package conv_enc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_ENCODE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } sched_state_t;

  localparam int unsigned SHORT_LEN_DEF = 132;
  localparam int unsigned LONG_LEN_DEF  = 768;
  localparam int unsigned CNT_W         = 10;

endpackage

// File: rtl/conv_enc_scheduler.sv
// Sequences one block through the encoder: start pulse, wait for completion
// (with watchdog), then drain target q0/q1/q2 triples under downstream flow control.
module conv_enc_scheduler
  import conv_enc_pkg::*;
#(
  parameter int unsigned SHORT_LEN = SHORT_LEN_DEF,
  parameter int unsigned LONG_LEN  = LONG_LEN_DEF,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       blk_ready,
  input  logic       len_sel,
  input  logic [7:0] tail_in,
  output logic       data_valid,
  output logic       code_block_length,
  output logic [7:0] tail_byte,
  input  logic       computation_done,
  output logic       rdreq_subblock,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       blk_done,
  output logic       timeout_err
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  sched_state_t     state, state_nx;
  logic             armed;
  logic             done_seen;
  logic             start;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] issued;
  logic [WD_W-1:0]  wdog;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      armed             <= 1'b0;
      done_seen         <= 1'b0;
      code_block_length <= 1'b0;
      tail_byte         <= '0;
      target            <= '0;
      issued            <= '0;
      wdog              <= '0;
      out_valid         <= 1'b0;
      out_last          <= 1'b0;
    end else begin
      state <= state_nx;

      // Re-arm only after blk_ready has been seen low, so a level held
      // high across blk_done cannot retrigger a block.
      if (state == ST_IDLE) begin
        if (start)
          armed <= 1'b0;
        else if (!blk_ready)
          armed <= 1'b1;
      end

      if (start) begin
        code_block_length <= len_sel;
        tail_byte         <= tail_in;
        target            <= len_sel ? CNT_W'(LONG_LEN) : CNT_W'(SHORT_LEN);
        issued            <= '0;
        done_seen         <= 1'b0;
      end else if ((state == ST_START || state == ST_ENCODE) && computation_done) begin
        done_seen <= 1'b1;
      end

      if (state == ST_START)
        wdog <= '0;
      else if (state == ST_ENCODE)
        wdog <= wdog + WD_W'(1);

      if (rdreq_subblock)
        issued <= issued + CNT_W'(1);

      out_valid <= rdreq_subblock;
      out_last  <= rdreq_subblock && (issued == target - CNT_W'(1));
    end
  end

  always_comb begin
    state_nx       = state;
    start          = 1'b0;
    data_valid     = 1'b0;
    rdreq_subblock = 1'b0;
    busy           = 1'b1;
    blk_done       = 1'b0;
    timeout_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (blk_ready && armed) begin
          start    = 1'b1;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        data_valid = 1'b1;
        state_nx   = ST_ENCODE;
      end
      ST_ENCODE: begin
        // A recorded completion wins over a simultaneous watchdog expiry.
        if (done_seen) begin
          state_nx = ST_DRAIN;
        end else if (wdog == WD_LAST) begin
          timeout_err = 1'b1;
          state_nx    = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        rdreq_subblock = out_ready && (issued < target);
        if (out_valid && out_last)
          state_nx = ST_DONE;
      end
      ST_DONE: begin
        blk_done = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_enc_scheduler.sv
// Directed-sequence bench for conv_enc_scheduler with randomized tail bytes
// and downstream back-pressure, checked against counts derived from block lengths.
module tb_conv_enc_scheduler;

  localparam int SHORT_N = 132;
  localparam int LONG_N  = 768;
  localparam int TMO     = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       blk_ready;
  logic       len_sel;
  logic [7:0] tail_in;
  logic       data_valid;
  logic       code_block_length;
  logic [7:0] tail_byte;
  logic       computation_done;
  logic       rdreq_subblock;
  logic       out_ready;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       blk_done;
  logic       timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  int dv_cnt = 0, rd_cnt = 0, ov_cnt = 0, bd_cnt = 0, to_cnt = 0, last_pos = 0;
  bit mon_en = 1'b0;
  bit rand_ready = 1'b0;
  logic prev_rd = 1'b0, prev_rst = 1'b1;

  conv_enc_scheduler #(.TIMEOUT(TMO)) dut (
    .clk              (clk),
    .reset            (reset),
    .blk_ready        (blk_ready),
    .len_sel          (len_sel),
    .tail_in          (tail_in),
    .data_valid       (data_valid),
    .code_block_length(code_block_length),
    .tail_byte        (tail_byte),
    .computation_done (computation_done),
    .rdreq_subblock   (rdreq_subblock),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_last         (out_last),
    .busy             (busy),
    .blk_done         (blk_done),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Downstream sink: always ready, or 50% random back-pressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Event counters plus per-cycle protocol rules.
  always @(negedge clk) begin
    if (data_valid === 1'b1) dv_cnt++;
    if (rdreq_subblock === 1'b1) rd_cnt++;
    if (out_valid === 1'b1) begin
      ov_cnt++;
      if (out_last === 1'b1) last_pos = ov_cnt;
    end
    if (blk_done === 1'b1) bd_cnt++;
    if (timeout_err === 1'b1) to_cnt++;
    if (mon_en) begin
      chk("ov_follows_rdreq", 32'(out_valid), 32'(prev_rd & ~prev_rst));
      chk("last_without_valid", 32'(out_last & ~out_valid), 32'd0);
      chk("rdreq_while_stalled", 32'(rdreq_subblock & ~out_ready), 32'd0);
    end
    prev_rd  = rdreq_subblock;
    prev_rst = reset;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "tb_conv_enc_scheduler hung");
  end

  task automatic check_zero(input string tag);
    chk({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_cbl"}, 32'(code_block_length), 32'd0);
    chk({tag, "_tail"}, 32'(tail_byte), 32'd0);
    chk({tag, "_rdreq"}, 32'(rdreq_subblock), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_blk_done"}, 32'(blk_done), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic wait_dv(input int base, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (dv_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_bd(input int base, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (bd_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 computation_done = 1'b1;
    @(posedge clk); #1 computation_done = 1'b0;
  endtask

  // Full block: rising blk_ready, completion 10 cycles after data_valid, drain, blk_done.
  task automatic run_block(input bit len, input string tag);
    int b_dv, b_rd, b_ov, b_bd, exp_n;
    bit ok;
    logic [7:0] t;
    exp_n = len ? LONG_N : SHORT_N;
    t = 8'($urandom);
    @(posedge clk); #1;
    blk_ready = 1'b0;
    len_sel   = len;
    tail_in   = t;
    b_dv = dv_cnt; b_rd = rd_cnt; b_ov = ov_cnt; b_bd = bd_cnt;
    @(posedge clk); #1 blk_ready = 1'b1;
    wait_dv(b_dv, 20, ok);
    chk({tag, "_dv_seen"}, 32'(ok), 32'd1);
    chk({tag, "_cbl_latched"}, 32'(code_block_length), 32'(len));
    chk({tag, "_tail_latched"}, 32'(tail_byte), 32'(t));
    len_sel = ~len;
    tail_in = ~t;
    repeat (9) @(posedge clk);
    pulse_done();
    wait_bd(b_bd, 4000, ok);
    chk({tag, "_blk_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_cbl_stable"}, 32'(code_block_length), 32'(len));
    chk({tag, "_tail_stable"}, 32'(tail_byte), 32'(t));
    chk({tag, "_last_position"}, 32'(last_pos - b_ov), 32'(exp_n));
    @(negedge clk); #1;
    chk({tag, "_dv_count"}, 32'(dv_cnt - b_dv), 32'd1);
    chk({tag, "_rdreq_count"}, 32'(rd_cnt - b_rd), 32'(exp_n));
    chk({tag, "_out_valid_count"}, 32'(ov_cnt - b_ov), 32'(exp_n));
    chk({tag, "_blk_done_count"}, 32'(bd_cnt - b_bd), 32'd1);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int b_dv, b_rd, b_ov, b_bd, b_to;
    bit ok;

    reset = 1'b1; blk_ready = 1'b0; len_sel = 1'b0; tail_in = '0;
    computation_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    // Short block, downstream always ready.
    run_block(1'b0, "short");

    // blk_ready stays high after blk_done: no retrigger; stray done ignored in IDLE.
    b_dv = dv_cnt;
    repeat (5) @(posedge clk);
    #1 computation_done = 1'b1;
    @(posedge clk); #1 computation_done = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    chk("held_ready_no_dv", 32'(dv_cnt - b_dv), 32'd0);
    chk("held_ready_idle", 32'(busy), 32'd0);

    // Long block with 50% back-pressure.
    rand_ready = 1'b1;
    run_block(1'b1, "long_bp");
    rand_ready = 1'b0;

    // Completion coincident with the data_valid cycle.
    @(posedge clk); #1;
    blk_ready = 1'b0; len_sel = 1'b0;
    b_dv = dv_cnt; b_rd = rd_cnt; b_bd = bd_cnt;
    @(posedge clk); #1 blk_ready = 1'b1;
    @(posedge clk); #1 computation_done = 1'b1;
    @(negedge clk); #1;
    chk("coinc_dv_high", 32'(data_valid), 32'd1);
    @(posedge clk); #1 computation_done = 1'b0;
    wait_bd(b_bd, 1000, ok);
    chk("coinc_blk_done_seen", 32'(ok), 32'd1);
    chk("coinc_rdreq_count", 32'(rd_cnt - b_rd), 32'(SHORT_N));

    // Watchdog: no completion at all.
    @(posedge clk); #1 blk_ready = 1'b0;
    b_rd = rd_cnt; b_to = to_cnt; b_bd = bd_cnt;
    @(posedge clk); #1 blk_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("tmo_dv_high", 32'(data_valid), 32'd1);
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk); #1;
      chk($sformatf("tmo_err_cycle%0d", i), 32'(timeout_err), 32'(i == TMO));
    end
    @(negedge clk); #1;
    chk("tmo_busy_low_after", 32'(busy), 32'd0);
    chk("tmo_err_single", 32'(to_cnt - b_to), 32'd1);
    chk("tmo_no_rdreq", 32'(rd_cnt - b_rd), 32'd0);
    chk("tmo_no_blk_done", 32'(bd_cnt - b_bd), 32'd0);

    // Reset after 50 reads: abandon block, no blk_done, no restart while held high.
    @(posedge clk); #1 blk_ready = 1'b0; len_sel = 1'b1;
    b_dv = dv_cnt; b_rd = rd_cnt; b_bd = bd_cnt;
    @(posedge clk); #1 blk_ready = 1'b1;
    wait_dv(b_dv, 20, ok);
    chk("rst_dv_seen", 32'(ok), 32'd1);
    pulse_done();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (rd_cnt - b_rd >= 50) begin ok = 1'b1; break; end
    end
    chk("rst_50_reads_reached", 32'(ok), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check_zero("midreset");
    reset = 1'b0;
    b_dv = dv_cnt;
    repeat (20) @(negedge clk);
    #1;
    chk("rst_no_blk_done", 32'(bd_cnt - b_bd), 32'd0);
    chk("rst_no_restart_held", 32'(dv_cnt - b_dv), 32'd0);
    chk("rst_idle", 32'(busy), 32'd0);

    // Fresh block after the abandoned one counts from zero.
    run_block(1'b0, "after_reset");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_enc_scheduler.md
CONV_ENC_SCHEDULER -- requirements
Module: conv_enc_scheduler

Interface
REQ-001 SHALL have parameter SHORT_LEN, default 132, meaning bytes per subblock for code_block_length=0.
REQ-002 SHALL have parameter LONG_LEN, default 768, meaning bytes per subblock for code_block_length=1.
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning max cycles in ENCODE awaiting computation_done.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on posedge clk.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port blk_ready, input, 1, level: input FIFO holds a complete block.
REQ-007 SHALL have port len_sel, input, 1, block length select (0 short, 1 long).
REQ-008 SHALL have port tail_in, input, 8, tail byte for next block.
REQ-009 SHALL have port data_valid, output, 1, one-cycle start pulse to encoder.
REQ-010 SHALL have port code_block_length, output, 1, latched len_sel to encoder.
REQ-011 SHALL have port tail_byte, output, 8, latched tail_in to encoder.
REQ-012 SHALL have port computation_done, input, 1, encoder finished pulse.
REQ-013 SHALL have port rdreq_subblock, output, 1, encoder q0/q1/q2 read request.
REQ-014 SHALL have port out_ready, input, 1, downstream can accept one q0/q1/q2 triple.
REQ-015 SHALL have port out_valid, output, 1, q0/q1/q2 valid this cycle.
REQ-016 SHALL have port out_last, output, 1, with out_valid: final triple of block.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port blk_done, output, 1, one-cycle pulse, block fully drained.
REQ-019 SHALL have port timeout_err, output, 1, one-cycle pulse on ENCODE watchdog expiry.

Function
REQ-020 SHALL implement states IDLE, START, ENCODE, DRAIN, DONE.
REQ-021 SHALL keep flag armed, set when blk_ready=0 sampled, cleared on leaving IDLE; a block starts only if blk_ready=1 and armed=1 in IDLE.
REQ-022 On start, SHALL latch len_sel into code_block_length and tail_in into tail_byte, load target = SHORT_LEN or LONG_LEN, go to START.
REQ-023 In START, SHALL assert data_valid for exactly one cycle, then go to ENCODE.
REQ-024 SHALL register computation_done if it arrives in START or ENCODE; ENCODE exits to DRAIN the cycle after it is seen.
REQ-025 SHALL count ENCODE cycles; on reaching TIMEOUT, pulse timeout_err and return to IDLE without draining.
REQ-026 In DRAIN, rdreq_subblock SHALL equal out_ready AND (issued < target); issued counter 10 bits, increments per rdreq.
REQ-027 out_valid SHALL be rdreq_subblock delayed one cycle (encoder read latency 1); out_last SHALL be high with out_valid for the triple issued at issued = target-1.
REQ-028 out_ready low SHALL stall issuing with no loss; no more than target reads SHALL be issued.
REQ-029 After out_last is emitted, SHALL go to DONE, pulse blk_done one cycle, return to IDLE.
REQ-030 SHALL ignore computation_done outside START/ENCODE and blk_ready outside IDLE.
REQ-031 code_block_length and tail_byte SHALL hold stable from START through DONE.

Reset
REQ-032 reset SHALL, synchronously and in any state, force IDLE, armed=0, counters=0, and all outputs to 0 on the next edge.
REQ-033 Reset mid-block SHALL abandon the block with no blk_done; restart requires blk_ready low then high.

Structure
REQ-034 State encoding, SHORT_LEN/LONG_LEN defaults and counter width SHALL live in shared package conv_enc_pkg.
REQ-035 Single module; no sub-module; only one FSM and two counters (issued, watchdog).

Verification
REQ-036 Short block: blk_ready 0->1, len_sel=0, out_ready=1, done 10 cycles after data_valid -> one data_valid pulse, 132 rdreq, 132 out_valid, out_last on 132nd, blk_done once.
REQ-037 Long block with out_ready toggling 50% -> exactly 768 out_valid, none lost or duplicated, out_last on 768th.
REQ-038 blk_ready held high after blk_done -> no second data_valid until blk_ready drops and rises.
REQ-039 computation_done coincident with data_valid -> DRAIN entered; never withheld.
REQ-040 No computation_done, TIMEOUT=16 -> timeout_err pulse at 16th ENCODE cycle, busy low next cycle, zero rdreq.
REQ-041 reset asserted after 50 reads -> all outputs 0 next edge, no blk_done, next block counts from 0.
